// File: rtl/edulent_datapath_p.sv
// EduLent accumulator data path: programmer-visible registers, register-transfer commands,
// req/ack memory port and a Z/N/C/V ALU. Define EDULENT_MUL_EN for the multi-cycle multiply (op B).
module edulent_datapath_p #(
   parameter int unsigned         DATA_W  = 8,
   parameter int unsigned         ADDR_W  = 8,
   parameter logic [ADDR_W-1:0]   SP_INIT = {ADDR_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_xfer_valid,
   input  logic [3:0]        i_xfer_cmd,
   input  logic              i_dst_ap,
   output logic              o_xfer_ready,
   input  logic              i_alu_start,
   input  logic [3:0]        i_alu_op,
   output logic              o_alu_busy,
   input  logic              i_inc_pc,
   input  logic [1:0]        i_sp_op,
   input  logic [DATA_W-1:0] i_in,
   output logic [DATA_W-1:0] o_out,
   output logic [DATA_W-1:0] o_ir,
   output logic [3:0]        o_flags,
   output logic [1:0]        o_sp_err,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack
);

   localparam int unsigned MSB = DATA_W - 1;

   localparam logic [3:0] CMD_MA_PC = 4'h1, CMD_MD_MEM = 4'h2, CMD_IR_MD = 4'h3, CMD_MA_MD = 4'h4;
   localparam logic [3:0] CMD_A_MD  = 4'h5, CMD_MA_AP  = 4'h6, CMD_MA_SP = 4'h7, CMD_MD_A  = 4'h8;
   localparam logic [3:0] CMD_MEM_MD = 4'h9, CMD_A_R  = 4'hA, CMD_PC_MD = 4'hB, CMD_A_IN  = 4'hC;
   localparam logic [3:0] CMD_OUT_A = 4'hD, CMD_PC_AP  = 4'hE, CMD_MD_PC = 4'hF;

   localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_NOT = 4'h2, ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_AND = 4'h4, ALU_XOR = 4'h5, ALU_PASS = 4'h6, ALU_SHL = 4'h7;
   localparam logic [3:0] ALU_SHR = 4'h8, ALU_ADC = 4'h9, ALU_SBB = 4'hA, ALU_MUL = 4'hB;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} mem_state_t;

   mem_state_t        state;
   logic              mem_wr;
   logic [ADDR_W-1:0] pc_q, sp_q, ma_q;
   logic [DATA_W-1:0] md_q, ir_q, a_q, ap_q, r_q, in_q, out_q;

   logic              cmd_acc, mem_start, mem_done, alu_go, busy_nxt;
   logic              mul_last, mul_hi_nz;
   logic [DATA_W-1:0] mul_res;

   assign cmd_acc   = i_xfer_valid && o_xfer_ready;
   assign mem_start = cmd_acc && ((i_xfer_cmd == CMD_MD_MEM) || (i_xfer_cmd == CMD_MEM_MD));
   assign mem_done  = (state == ST_WAIT) && i_mem_ack;
   assign alu_go    = i_alu_start && !o_alu_busy;

   assign o_out       = out_q;
   assign o_ir        = ir_q;
   assign o_mem_addr  = ma_q;
   assign o_mem_wdata = md_q;

   // Single-cycle ALU result and flags
   logic [DATA_W:0]   alu_sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v, alu_hit;

   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_hit = 1'b1;
      case (i_alu_op)
         ALU_ADD, ALU_ADC: begin
            alu_sum = {1'b0, a_q} + {1'b0, md_q}
                    + ((i_alu_op == ALU_ADC) ? (DATA_W+1)'(o_flags[1]) : '0);
            alu_res = alu_sum[MSB:0];
            alu_c   = alu_sum[DATA_W];
            alu_v   = (a_q[MSB] == md_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
         end
         ALU_SUB, ALU_SBB: begin
            alu_sum = {1'b0, a_q} - {1'b0, md_q}
                    - ((i_alu_op == ALU_SBB) ? (DATA_W+1)'(o_flags[1]) : '0);
            alu_res = alu_sum[MSB:0];
            alu_c   = alu_sum[DATA_W];
            alu_v   = (a_q[MSB] != md_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
         end
         ALU_NOT:  alu_res = ~a_q;
         ALU_OR:   alu_res = a_q | md_q;
         ALU_AND:  alu_res = a_q & md_q;
         ALU_XOR:  alu_res = a_q ^ md_q;
         ALU_PASS: alu_res = a_q;
         ALU_SHL: begin
            alu_res = {a_q[MSB-1:0], 1'b0};
            alu_c   = a_q[MSB];
         end
         ALU_SHR: begin
            alu_res = {1'b0, a_q[MSB:1]};
            alu_c   = a_q[0];
         end
         default:  alu_hit = 1'b0;
      endcase
   end

`ifdef EDULENT_MUL_EN
   // Shift-add multiplier: one partial product per cycle, DATA_W cycles
   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   logic                mul_busy;
   logic [CNT_W-1:0]    mul_cnt;
   logic [2*DATA_W-1:0] mul_acc, mul_mcand, mul_sum;
   logic [DATA_W-1:0]   mul_mplier;
   logic                mul_start;

   assign mul_start  = alu_go && (i_alu_op == ALU_MUL);
   assign mul_last   = mul_busy && (mul_cnt == CNT_W'(1));
   assign mul_sum    = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
   assign mul_res    = mul_sum[MSB:0];
   assign mul_hi_nz  = |mul_sum[2*DATA_W-1:DATA_W];
   assign busy_nxt   = mul_start || (mul_busy && !mul_last);
   assign o_alu_busy = mul_busy;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         mul_busy   <= 1'b0;
         mul_cnt    <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else if (mul_start) begin
         mul_busy   <= 1'b1;
         mul_cnt    <= CNT_W'(DATA_W);
         mul_acc    <= '0;
         mul_mcand  <= (2*DATA_W)'(a_q);
         mul_mplier <= md_q;
      end else if (mul_busy) begin
         mul_acc    <= mul_sum;
         mul_mcand  <= {mul_mcand[2*DATA_W-2:0], 1'b0};
         mul_mplier <= {1'b0, mul_mplier[MSB:1]};
         mul_cnt    <= mul_cnt - CNT_W'(1);
         mul_busy   <= !mul_last;
      end
   end
`else
   assign mul_last   = 1'b0;
   assign mul_res    = '0;
   assign mul_hi_nz  = 1'b0;
   assign busy_nxt   = 1'b0;
   assign o_alu_busy = 1'b0;
`endif

   // Memory handshake FSM: one issue cycle, then request held until ack
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= ST_IDLE;
         mem_wr       <= 1'b0;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_xfer_ready <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_start) begin
                  state        <= ST_ISSUE;
                  mem_wr       <= (i_xfer_cmd == CMD_MEM_MD);
                  o_xfer_ready <= 1'b0;
               end else begin
                  o_xfer_ready <= !busy_nxt;
               end
            end
            ST_ISSUE: begin
               state     <= ST_WAIT;
               o_mem_req <= 1'b1;
               o_mem_we  <= mem_wr;
            end
            ST_WAIT: begin
               if (i_mem_ack) begin
                  state        <= ST_IDLE;
                  o_mem_req    <= 1'b0;
                  o_mem_we     <= 1'b0;
                  o_xfer_ready <= !busy_nxt;
               end
            end
            default: begin
               state     <= ST_IDLE;
               o_mem_req <= 1'b0;
               o_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   // Register file: transfer commands, PC/SP counters, ALU write-back
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pc_q     <= '0;
         sp_q     <= SP_INIT;
         ma_q     <= '0;
         md_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         ap_q     <= '0;
         r_q      <= '0;
         in_q     <= '0;
         out_q    <= '0;
         o_flags  <= '0;
         o_sp_err <= '0;
      end else begin
         in_q <= i_in;

         if (i_inc_pc) pc_q <= pc_q + ADDR_W'(1);

         case (i_sp_op)
            2'b01: begin
               sp_q <= sp_q + ADDR_W'(1);
               if (sp_q == {ADDR_W{1'b1}}) o_sp_err[1] <= 1'b1;
            end
            2'b10: begin
               sp_q <= sp_q - ADDR_W'(1);
               if (sp_q == '0) o_sp_err[0] <= 1'b1;
            end
            default: ;
         endcase

         if (mem_done && !mem_wr) md_q <= i_mem_rdata;

         if (cmd_acc) begin
            case (i_xfer_cmd)
               CMD_MA_PC:  ma_q <= pc_q;
               CMD_IR_MD:  ir_q <= md_q;
               CMD_MA_MD:  ma_q <= ADDR_W'(md_q);
               CMD_A_MD:   if (i_dst_ap) ap_q <= md_q; else a_q <= md_q;
               CMD_MA_AP:  ma_q <= ADDR_W'(ap_q);
               CMD_MA_SP:  ma_q <= sp_q;
               CMD_MD_A:   md_q <= i_dst_ap ? ap_q : a_q;
               CMD_A_R:    if (i_dst_ap) ap_q <= r_q; else a_q <= r_q;
               CMD_PC_MD:  pc_q <= ADDR_W'(md_q);
               CMD_A_IN:   a_q <= in_q;
               CMD_OUT_A:  out_q <= a_q;
               CMD_PC_AP:  pc_q <= ADDR_W'(ap_q);
               CMD_MD_PC:  md_q <= DATA_W'(pc_q);
               default: ;
            endcase
         end

         if (mul_last) begin
            r_q     <= mul_res;
            o_flags <= {mul_res == '0, mul_res[MSB], mul_hi_nz, mul_hi_nz};
         end else if (alu_go && alu_hit) begin
            r_q     <= alu_res;
            o_flags <= {alu_res == '0, alu_res[MSB], alu_c, alu_v};
         end
      end
   end

endmodule

// File: tb/tb_edulent_datapath_p.sv
// Directed self-checking bench for edulent_datapath_p (8-bit default parameters).
module tb_edulent_datapath_p;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_xfer_valid = 1'b0;
   logic [3:0] i_xfer_cmd = 4'h0;
   logic       i_dst_ap = 1'b0;
   logic       o_xfer_ready;
   logic       i_alu_start = 1'b0;
   logic [3:0] i_alu_op = 4'h0;
   logic       o_alu_busy;
   logic       i_inc_pc = 1'b0;
   logic [1:0] i_sp_op = 2'b00;
   logic [7:0] i_in = 8'h00;
   logic [7:0] o_out, o_ir;
   logic [3:0] o_flags;
   logic [1:0] o_sp_err;
   logic       o_mem_req, o_mem_we;
   logic [7:0] o_mem_addr, o_mem_wdata;
   logic [7:0] i_mem_rdata = 8'h00;
   logic       i_mem_ack = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   edulent_datapath_p dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_xfer_valid(i_xfer_valid), .i_xfer_cmd(i_xfer_cmd), .i_dst_ap(i_dst_ap),
      .o_xfer_ready(o_xfer_ready),
      .i_alu_start(i_alu_start), .i_alu_op(i_alu_op), .o_alu_busy(o_alu_busy),
      .i_inc_pc(i_inc_pc), .i_sp_op(i_sp_op),
      .i_in(i_in), .o_out(o_out), .o_ir(o_ir), .o_flags(o_flags), .o_sp_err(o_sp_err),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // All helpers start and end on a falling edge
   task automatic cmd(input logic [3:0] c, input logic ap);
      i_xfer_valid = 1'b1;
      i_xfer_cmd   = c;
      i_dst_ap     = ap;
      @(negedge i_clk);
      i_xfer_valid = 1'b0;
      i_dst_ap     = 1'b0;
   endtask

   task automatic alu(input logic [3:0] op);
      i_alu_start = 1'b1;
      i_alu_op    = op;
      @(negedge i_clk);
      i_alu_start = 1'b0;
   endtask

   task automatic set_a(input logic [7:0] v);
      i_in = v;
      @(negedge i_clk);
      cmd(4'hC, 1'b0);
   endtask

   task automatic set_md(input logic [7:0] v);
      set_a(v);
      cmd(4'h8, 1'b0);
   endtask

   task automatic check_r(input string tag, input logic [7:0] exp);
      cmd(4'hA, 1'b0);
      cmd(4'hD, 1'b0);
      check(tag, o_out, exp);
   endtask

   task automatic mem_access(input logic [3:0] c, input int waits, input logic [7:0] rd,
                             input logic we_exp);
      int t;
      cmd(c, 1'b0);
      check("mem_issue_noreq", o_mem_req, 1'b0);
      t = 0;
      while (!o_mem_req && t < 16) begin
         @(negedge i_clk);
         t++;
      end
      check("mem_req_latency", t, 1);
      check("mem_we", o_mem_we, we_exp);
      check("mem_ready_low", o_xfer_ready, 1'b0);
      repeat (waits) @(negedge i_clk);
      check("mem_req_held", o_mem_req, 1'b1);
      i_mem_ack   = 1'b1;
      i_mem_rdata = rd;
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      check("mem_req_drop", o_mem_req, 1'b0);
      check("mem_ready_back", o_xfer_ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge i_clk);
      check("rst_req", o_mem_req, 1'b0);
      check("rst_we", o_mem_we, 1'b0);
      check("rst_ready", o_xfer_ready, 1'b1);
      check("rst_busy", o_alu_busy, 1'b0);
      check("rst_flags", o_flags, 4'h0);
      check("rst_sperr", o_sp_err, 2'b00);
      check("rst_ma", o_mem_addr, 8'h00);
      check("rst_md", o_mem_wdata, 8'h00);
      check("rst_out", o_out, 8'h00);
      check("rst_ir", o_ir, 8'h00);
      i_rstn = 1'b1;
      @(negedge i_clk);

      cmd(4'h7, 1'b0);
      check("ma_sp_init", o_mem_addr, 8'hFF);

      i_inc_pc = 1'b1;
      repeat (5) @(negedge i_clk);
      i_inc_pc = 1'b0;
      cmd(4'h1, 1'b0);
      check("pc_inc5", o_mem_addr, 8'h05);

      // Jump beats increment on the same edge
      set_md(8'h40);
      check("md_from_a", o_mem_wdata, 8'h40);
      i_inc_pc = 1'b1;
      cmd(4'hB, 1'b0);
      i_inc_pc = 1'b0;
      cmd(4'h1, 1'b0);
      check("pc_jump_md", o_mem_addr, 8'h40);

      set_md(8'h10);
      cmd(4'h4, 1'b0);
      check("ma_from_md", o_mem_addr, 8'h10);
      mem_access(4'h2, 3, 8'hA5, 1'b0);
      check("read_md", o_mem_wdata, 8'hA5);
      cmd(4'h3, 1'b0);
      check("ir_from_md", o_ir, 8'hA5);

      i_mem_ack   = 1'b1;
      i_mem_rdata = 8'h55;
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      check("idle_ack_md", o_mem_wdata, 8'hA5);
      check("idle_ack_ready", o_xfer_ready, 1'b1);

      set_md(8'h3C);
      cmd(4'h4, 1'b0);
      mem_access(4'h9, 0, 8'hEE, 1'b1);
      check("write_md_kept", o_mem_wdata, 8'h3C);
      check("write_addr", o_mem_addr, 8'h3C);

      set_md(8'h01);
      set_a(8'h7F);
      alu(4'h0);
      check("add_flags", o_flags, 4'b0101);
      check_r("add_r", 8'h80);

      set_md(8'h01);
      set_a(8'h00);
      alu(4'h1);
      check("sub_flags", o_flags, 4'b0110);
      check_r("sub_r", 8'hFF);

      set_md(8'h01);
      set_a(8'h05);
      alu(4'h9);
      check("adc_flags", o_flags, 4'b0000);
      check_r("adc_r", 8'h07);

      set_a(8'h81);
      alu(4'h8);
      check("shr_flags", o_flags, 4'b0010);
      check_r("shr_r", 8'h40);

      set_md(8'h0F);
      set_a(8'h0F);
      alu(4'h5);
      check("xor_flags", o_flags, 4'b1000);
      alu(4'hC);
      check("reserved_flags", o_flags, 4'b1000);

      // AP is a separate destination from A
      set_md(8'h2B);
      set_a(8'h11);
      cmd(4'h5, 1'b1);
      cmd(4'h6, 1'b0);
      check("ma_from_ap", o_mem_addr, 8'h2B);
      cmd(4'hD, 1'b0);
      check("a_untouched", o_out, 8'h11);
      set_md(8'h99);
      cmd(4'hE, 1'b0);
      cmd(4'hF, 1'b0);
      check("pc_ap_md_pc", o_mem_wdata, 8'h2B);

      set_md(8'h10);
      set_a(8'h12);
`ifdef EDULENT_MUL_EN
      alu(4'hB);
      for (int i = 0; i < 8; i++) begin
         check("mul_busy", o_alu_busy, 1'b1);
         check("mul_ready_low", o_xfer_ready, 1'b0);
         @(negedge i_clk);
      end
      check("mul_busy_end", o_alu_busy, 1'b0);
      check("mul_ready_end", o_xfer_ready, 1'b1);
      check("mul_flags", o_flags, 4'b0011);
      check_r("mul_r", 8'h20);
`else
      alu(4'hB);
      check("mul_off_busy", o_alu_busy, 1'b0);
      check("mul_off_flags", o_flags, 4'b1000);
      check_r("mul_off_r", 8'h00);
`endif

      // Reset while a read is outstanding and ack is being driven
      cmd(4'h2, 1'b0);
      @(negedge i_clk);
      check("pre_rst_req", o_mem_req, 1'b1);
      i_mem_ack   = 1'b1;
      i_mem_rdata = 8'h77;
      i_rstn      = 1'b0;
      #1;
      check("midrst_req", o_mem_req, 1'b0);
      check("midrst_ready", o_xfer_ready, 1'b1);
      check("midrst_md", o_mem_wdata, 8'h00);
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      @(negedge i_clk);
      i_rstn = 1'b1;
      @(negedge i_clk);
      check("postrst_md", o_mem_wdata, 8'h00);
      check("postrst_out", o_out, 8'h00);

      // SP: code 7 reads pre-update value, then walk down to 0 and wrap both ways
      i_sp_op = 2'b10;
      cmd(4'h7, 1'b0);
      check("sp_pre_update", o_mem_addr, 8'hFF);
      repeat (254) @(negedge i_clk);
      i_sp_op = 2'b00;
      cmd(4'h7, 1'b0);
      check("sp_zero", o_mem_addr, 8'h00);
      check("sp_err_none", o_sp_err, 2'b00);
      i_sp_op = 2'b10;
      @(negedge i_clk);
      i_sp_op = 2'b00;
      cmd(4'h7, 1'b0);
      check("sp_dec_wrap", o_mem_addr, 8'hFF);
      check("sp_err_dec", o_sp_err, 2'b01);
      i_sp_op = 2'b01;
      @(negedge i_clk);
      i_sp_op = 2'b00;
      cmd(4'h7, 1'b0);
      check("sp_inc_wrap", o_mem_addr, 8'h00);
      check("sp_err_both", o_sp_err, 2'b11);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/edulent_datapath_p.md
# edulent_datapath_p

Parametrised successor to the EduLent accumulator data path. It holds the programmer-visible registers (PC, IR, SP, MA, MD, A, AP, R, IN, OUT, STATUS) and executes one register-transfer command per handshake. Memory accesses use a req/ack handshake with wait states; the ALU updates Z/N/C/V flags. It sits between the control unit and the memory/IO ports.

## Interface
- DATA_W, 8, width of A, AP, R, MD, IR, IN, OUT, memory data
- ADDR_W, 8, width of PC, SP, MA, memory address
- SP_INIT, 2**ADDR_W-1, SP value after reset
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_xfer_valid  in  1  transfer command strobe
- i_xfer_cmd  in  4  transfer code, see Operation
- i_dst_ap  in  1  selects AP instead of A for codes 5, 8, A
- o_xfer_ready  out  1  datapath accepts a command this cycle
- i_alu_start  in  1  start ALU op
- i_alu_op  in  4  ALU operation code
- o_alu_busy  out  1  multi-cycle ALU op in progress
- i_inc_pc  in  1  PC <= PC+1
- i_sp_op  in  2  01 SP+1, 10 SP-1, 00/11 hold
- i_in  in  DATA_W  input port
- o_out  out  DATA_W  OUT register
- o_ir  out  DATA_W  IR register, for the controller
- o_flags  out  4  {Z,N,C,V}
- o_sp_err  out  2  sticky {inc-wrap, dec-wrap}
- o_mem_req, o_mem_we  out  1  memory request, write enable
- o_mem_addr  out  ADDR_W  always MA
- o_mem_wdata  out  DATA_W  always MD
- i_mem_rdata  in  DATA_W  read data, valid with ack
- i_mem_ack  in  1  memory completion

## Operation
- Command accepted when i_xfer_valid && o_xfer_ready. Codes: 0 nop; 1 MA<-PC; 2 MD<-M[MA]; 3 IR<-MD; 4 MA<-MD; 5 A/AP<-MD; 6 MA<-AP; 7 MA<-SP; 8 MD<-A/AP; 9 M[MA]<-MD; A A/AP<-R; B PC<-MD; C A<-IN; D OUT<-A; E PC<-AP; F MD<-PC.
- Width crossing: DATA_W->ADDR_W truncates or zero-extends; same reversed.
- Codes 2/9: FSM IDLE->REQ. In REQ, o_mem_req=1, o_mem_we=1 for code 9. On i_mem_ack: read captures MD<=i_mem_rdata; FSM->IDLE. Ack while IDLE ignored.
- o_xfer_ready = (FSM==IDLE) && !o_alu_busy.
- ALU ops (R<-f(A,MD), one cycle): 0 ADD, 1 SUB, 2 NOT A, 3 OR, 4 AND, 5 XOR, 6 PASS A, 7 SHL A, 8 SHR A (logical), 9 ADC, A SBB. B MUL (macro). Others: R and flags unchanged.
- Flags updated with R: Z=(R==0); N=R[MSB]; C=carry out (ADD/ADC), borrow (SUB/SBB), shifted-out bit (SHL/SHR), else 0; V=signed overflow for ADD/SUB/ADC/SBB, else 0.
- PC and SP wrap modulo 2**ADDR_W. SP 0->max sets o_sp_err[0]; max->0 sets o_sp_err[1]; sticky until reset.

## Timing
- Reset: all registers 0, SP=SP_INIT, FSM IDLE, o_mem_req=0, o_mem_we=0, o_xfer_ready=1, o_alu_busy=0, o_flags=0, o_sp_err=0.
- Reset mid-access: o_mem_req drops immediately; partial transfer discarded.
- Register codes update destination at the accepting edge. Memory codes: o_mem_req high from the next cycle; zero-wait ack gives ready again 2 cycles after accept; each wait cycle adds one.
- ALU: R/flags valid one edge after i_alu_start. i_alu_start while busy ignored.
- Same-edge conflicts: code B/E beats i_inc_pc; i_sp_op applies alongside any command (code 7 reads pre-update SP).

## Configuration
- EDULENT_MUL_EN defined: op B is a DATA_W-cycle shift-add multiply. o_alu_busy high from the edge after start for DATA_W cycles; R = low half of A*MD; C=V=(high half != 0); Z/N from R.
- Not defined: op B is reserved (no change); o_alu_busy tied 0.

## Test plan
- Reset mid-read with ack pending -> o_mem_req=0, MD=0, SP=8'hFF, o_xfer_ready=1.
- Code 2 with MA=8'h10, ack after 3 wait cycles, rdata 8'hA5 -> MD=8'hA5, ready returns the edge after ack.
- A=8'h7F, MD=8'h01, ADD -> R=8'h80, flags Z0 N1 C0 V1; SUB with A=8'h00, MD=8'h01 -> R=8'hFF, C1.
- SP=8'h00, i_sp_op=10 -> SP=8'hFF, o_sp_err=2'b01; then sp_op=01 -> SP=8'h00, o_sp_err=2'b11.
- i_inc_pc with code B (MD=8'h40) on PC=8'h05 -> PC=8'h40.
- EDULENT_MUL_EN: A=8'h12, MD=8'h10 MUL -> busy 8 cycles, R=8'h20, C=V=1.
